// File: rtl/issue_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : issue_scheduler_pkg / issue_scheduler_if
//  Purpose  : Shared types for the issue scheduler (opcode, decoded
//             instruction, FSM state) and the interface that carries the
//             decoder-side push port, the execute-side issue port, the
//             writeback/HI-LO completion inputs, flush and busy.
//  Ports    : master = decoder/execute environment, slave = scheduler.
//               flush, in_valid, in_instr, in_pc, issue_ready,
//               wb_valid, wb_rd, hilo_done              (master -> slave)
//               in_ready, issue_valid, issue_instr,
//               issue_pc, busy                          (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
package issue_scheduler_pkg;

    typedef enum logic [5:0] {
        OP_NOP     = 6'd0,
        OP_ADDU    = 6'd1,
        OP_LW      = 6'd2,
        OP_SW      = 6'd3,
        OP_MULT    = 6'd4,
        OP_MULTU   = 6'd5,
        OP_DIV     = 6'd6,
        OP_DIVU    = 6'd7,
        OP_MADD    = 6'd8,
        OP_MADDU   = 6'd9,
        OP_MSUB    = 6'd10,
        OP_MSUBU   = 6'd11,
        OP_MFHI    = 6'd12,
        OP_MFLO    = 6'd13,
        OP_MTHI    = 6'd14,
        OP_MTLO    = 6'd15,
        OP_SYSCALL = 6'd16,
        OP_BREAK   = 6'd17,
        OP_CACHE   = 6'd18,
        OP_LL      = 6'd19,
        OP_SC      = 6'd20
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        is_load;
        logic [15:0] imm;
    } decoded_instr_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } sched_state_e;

    // Ops that read or write HI/LO and therefore wait on an in-flight
    // mult/div result.
    function automatic logic uses_hilo(op_e op);
        case (op)
            OP_MFHI, OP_MFLO, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO:
                uses_hilo = 1'b1;
            default:
                uses_hilo = 1'b0;
        endcase
    endfunction

    // Ops whose HI/LO result arrives later via hilo_done.
    function automatic logic produces_hilo(op_e op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:
                produces_hilo = 1'b1;
            default:
                produces_hilo = 1'b0;
        endcase
    endfunction

    // Ops that may only leave once every long-latency producer retired.
    function automatic logic is_serializing(op_e op);
        case (op)
            OP_SYSCALL, OP_BREAK, OP_CACHE, OP_LL, OP_SC:
                is_serializing = 1'b1;
            default:
                is_serializing = 1'b0;
        endcase
    endfunction

endpackage

interface issue_scheduler_if;
    import issue_scheduler_pkg::*;

    logic           flush;
    logic           in_valid;
    logic           in_ready;
    decoded_instr_t in_instr;
    logic [31:0]    in_pc;
    logic           issue_valid;
    logic           issue_ready;
    decoded_instr_t issue_instr;
    logic [31:0]    issue_pc;
    logic           wb_valid;
    logic [4:0]     wb_rd;
    logic           hilo_done;
    logic           busy;

    modport master (
        output flush, in_valid, in_instr, in_pc, issue_ready,
               wb_valid, wb_rd, hilo_done,
        input  in_ready, issue_valid, issue_instr, issue_pc, busy
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, issue_ready,
               wb_valid, wb_rd, hilo_done,
        output in_ready, issue_valid, issue_instr, issue_pc, busy
    );

endinterface
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : issue_scheduler
//  Purpose  : In-order issue buffer between decode and execute. Decoded
//             instructions are queued in a DEPTH-entry FIFO; the head issues
//             when it has no RAW/WAW hazard against long-latency producers
//             tracked in a scoreboard (32 GPR bits + one HI/LO bit).
//             SYSCALL/BREAK/CACHE/LL/SC wait until the scoreboard is empty.
//  Ports    : clk          clock
//             rst_n        synchronous reset, active low
//             bus (slave)  push port, issue port, writeback/HI-LO completion,
//                          flush and busy (see issue_scheduler_if)
//  Params   : DEPTH       FIFO entries, power of two, >= 2
//             WB_FORWARD  1: a scoreboard bit cleared this cycle is already
//                         treated as clear by the hazard check
//  Revision : 1.0  initial release
// ============================================================================
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter bit WB_FORWARD = 1'b0
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    issue_scheduler_if.slave    bus
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    decoded_instr_t         instr_mem_q [DEPTH];
    logic [31:0]            pc_mem_q    [DEPTH];
    logic [C_PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0]     count_q,  count_d;
    logic [31:0]            sb_q,     sb_d;
    logic                   sb_hilo_q, sb_hilo_d;
    sched_state_e           state_q,  state_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                   w_empty;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    decoded_instr_t         w_head;
    logic [31:0]            w_head_pc;
    logic [31:0]            w_wb_clr;
    logic [31:0]            w_sb_view;
    logic                   w_hilo_view;
    logic                   w_hazard;
    logic [31:0]            w_sb_set;
    logic                   w_hilo_set;
    logic                   w_sb_nonzero;
    logic                   w_sb_next_nonzero;
    logic                   w_head_serial;
    logic                   w_issue_valid;

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == C_FULL);
    assign w_head    = instr_mem_q[rd_ptr_q];
    assign w_head_pc = pc_mem_q[rd_ptr_q];

    // A push arriving together with flush is dropped: the queue it would
    // land in is being discarded.
    assign w_push = bus.in_valid && !w_full && !bus.flush;
    assign w_pop  = w_issue_valid && bus.issue_ready;

    assign w_sb_nonzero  = (|sb_q) || sb_hilo_q;
    assign w_head_serial = is_serializing(w_head.op);

    // ------------------------------------------------------------------
    // Hazard check on the FIFO head
    // ------------------------------------------------------------------
    always_comb begin
        w_wb_clr = '0;
        if (bus.wb_valid && (bus.wb_rd != 5'd0)) begin
            w_wb_clr[bus.wb_rd] = 1'b1;
        end

        // With forwarding the writeback in flight this cycle already
        // satisfies the consumer, so mask it out of the view.
        w_sb_view   = WB_FORWARD ? (sb_q & ~w_wb_clr) : sb_q;
        w_hilo_view = WB_FORWARD ? (sb_hilo_q && !bus.hilo_done) : sb_hilo_q;

        w_hazard = 1'b0;
        if ((w_head.rs1 != 5'd0) && w_sb_view[w_head.rs1]) begin
            w_hazard = 1'b1;
        end
        if ((w_head.rs2 != 5'd0) && w_sb_view[w_head.rs2]) begin
            w_hazard = 1'b1;
        end
        if ((w_head.rd != 5'd0) && w_sb_view[w_head.rd]) begin
            w_hazard = 1'b1;
        end
        if (uses_hilo(w_head.op) && w_hilo_view) begin
            w_hazard = 1'b1;
        end
    end

    // Serializing ops look at the registered scoreboard, so they always
    // leave one cycle after the last producer has written back.
    assign w_issue_valid = !w_empty
                        && !w_hazard
                        && !(w_head_serial && w_sb_nonzero)
                        && !((state_q == ST_DRAIN) && w_sb_nonzero)
                        && !bus.flush;

    // ------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------
    always_comb begin
        w_sb_set   = '0;
        w_hilo_set = 1'b0;
        if (w_pop) begin
            if ((w_head.is_load || (w_head.op == OP_LL)) && (w_head.rd != 5'd0)) begin
                w_sb_set[w_head.rd] = 1'b1;
            end
            if (produces_hilo(w_head.op)) begin
                w_hilo_set = 1'b1;
            end
        end
        // Set is applied after clear: a register re-issued as a new
        // producer in the same cycle its old value returns stays busy.
        sb_d      = (sb_q & ~w_wb_clr) | w_sb_set;
        sb_hilo_d = (sb_hilo_q && !bus.hilo_done) || w_hilo_set;
    end

    assign w_sb_next_nonzero = (|sb_d) || sb_hilo_d;

    // ------------------------------------------------------------------
    // FIFO pointer / count next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + C_PTR_W'(w_push);
        rd_ptr_d = rd_ptr_q + C_PTR_W'(w_pop);
        count_d  = count_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!w_empty && w_head_serial && w_sb_nonzero) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the scoreboard will be empty so the held
                // op issues on the very next cycle.
                if (!w_sb_next_nonzero) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (bus.flush) begin
            state_d = ST_RUN;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sb_q      <= '0;
            sb_hilo_q <= 1'b0;
            state_q   <= ST_RUN;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sb_q      <= sb_d;
            sb_hilo_q <= sb_hilo_d;
            state_q   <= state_d;
        end
    end

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            instr_mem_q[wr_ptr_q] <= bus.in_instr;
            pc_mem_q[wr_ptr_q]    <= bus.in_pc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = !w_full;
    assign bus.issue_valid = w_issue_valid;
    assign bus.issue_instr = w_head;
    assign bus.issue_pc    = w_head_pc;
    assign bus.busy        = !w_empty || w_sb_nonzero;

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_scheduler
//  Purpose  : Directed self-checking bench for issue_scheduler. Two
//             instances share one stimulus stream: dut0 with WB_FORWARD=0
//             and dut1 with WB_FORWARD=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    issue_scheduler_if bus0 ();
    issue_scheduler_if bus1 ();

    assign bus1.flush       = bus0.flush;
    assign bus1.in_valid    = bus0.in_valid;
    assign bus1.in_instr    = bus0.in_instr;
    assign bus1.in_pc       = bus0.in_pc;
    assign bus1.issue_ready = bus0.issue_ready;
    assign bus1.wb_valid    = bus0.wb_valid;
    assign bus1.wb_rd       = bus0.wb_rd;
    assign bus1.hilo_done   = bus0.hilo_done;

    issue_scheduler #(.DEPTH(8), .WB_FORWARD(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    issue_scheduler #(.DEPTH(8), .WB_FORWARD(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    function automatic decoded_instr_t mk(op_e op, logic [4:0] rs1, logic [4:0] rs2,
                                          logic [4:0] rd, logic ld);
        decoded_instr_t d;
        d.op      = op;
        d.rs1     = rs1;
        d.rs2     = rs2;
        d.rd      = rd;
        d.is_load = ld;
        d.imm     = 16'h0;
        return d;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(op_e op, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                         logic ld, logic [31:0] pc);
        bus0.in_valid = 1'b1;
        bus0.in_instr = mk(op, rs1, rs2, rd, ld);
        bus0.in_pc    = pc;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus0.flush       = 1'b0;
        bus0.in_valid    = 1'b0;
        bus0.in_instr    = mk(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        bus0.in_pc       = 32'h0;
        bus0.issue_ready = 1'b0;
        bus0.wb_valid    = 1'b0;
        bus0.wb_rd       = 5'd0;
        bus0.hilo_done   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus0.in_ready); end
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL reset_issue_valid: got %b want 0", bus0.issue_valid); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
        n_cmp++; if (dut0.state_q !== ST_RUN) begin n_err++; $display("FAIL reset_state: got %0d want RUN", dut0.state_q); end
    endtask

    task automatic test_basic();
        do_reset();
        bus0.issue_ready = 1'b1;
        drive(OP_ADDU, 5'd1, 5'd2, 5'd3, 1'b0, 32'h100);
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL basic_no_bypass: got %b want 0", bus0.issue_valid); end
        tick();
        bus0.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", bus0.issue_valid); end
        n_cmp++; if (bus0.issue_pc !== 32'h100) begin n_err++; $display("FAIL basic_pc: got %h want 00000100", bus0.issue_pc); end
        n_cmp++; if (bus0.issue_instr.rd !== 5'd3) begin n_err++; $display("FAIL basic_rd: got %0d want 3", bus0.issue_instr.rd); end
        tick();
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL basic_after_pop_valid: got %b want 0", bus0.issue_valid); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b want 0", bus0.busy); end
    endtask

    task automatic test_raw_load();
        do_reset();
        bus0.issue_ready = 1'b1;
        drive(OP_LW, 5'd1, 5'd0, 5'd5, 1'b1, 32'h200);
        tick();
        drive(OP_ADDU, 5'd5, 5'd2, 5'd6, 1'b0, 32'h204);
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== 32'h200) begin n_err++; $display("FAIL raw_lw_issue: got v=%b pc=%h want v=1 pc=00000200", bus0.issue_valid, bus0.issue_pc); end
        tick();
        bus0.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL raw_stall1: got %b want 0", bus0.issue_valid); end
        n_cmp++; if (dut0.sb_q !== 32'h0000_0020) begin n_err++; $display("FAIL raw_sb_set: got %h want 00000020", dut0.sb_q); end
        tick();
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL raw_stall2: got %b want 0", bus0.issue_valid); end
        bus0.wb_valid = 1'b1;
        bus0.wb_rd    = 5'd5;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL raw_nofwd_wb_cycle: got %b want 0", bus0.issue_valid); end
        n_cmp++; if (bus1.issue_valid !== 1'b1) begin n_err++; $display("FAIL raw_fwd_wb_cycle: got %b want 1", bus1.issue_valid); end
        tick();
        bus0.wb_valid = 1'b0;
        bus0.wb_rd    = 5'd0;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== 32'h204) begin n_err++; $display("FAIL raw_nofwd_after_wb: got v=%b pc=%h want v=1 pc=00000204", bus0.issue_valid, bus0.issue_pc); end
        tick();
        #1;
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL raw_busy_end: got %b want 0", bus0.busy); end
    endtask

    task automatic test_hilo();
        do_reset();
        bus0.issue_ready = 1'b1;
        drive(OP_MULT, 5'd1, 5'd2, 5'd0, 1'b0, 32'h300);
        tick();
        drive(OP_MFLO, 5'd0, 5'd0, 5'd8, 1'b0, 32'h304);
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== 32'h300) begin n_err++; $display("FAIL hilo_mult_issue: got v=%b pc=%h want v=1 pc=00000300", bus0.issue_valid, bus0.issue_pc); end
        tick();
        bus0.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL hilo_mflo_stall: got %b want 0", bus0.issue_valid); end
        tick();
        bus0.hilo_done = 1'b1;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL hilo_nofwd_done_cycle: got %b want 0", bus0.issue_valid); end
        n_cmp++; if (bus1.issue_valid !== 1'b1) begin n_err++; $display("FAIL hilo_fwd_done_cycle: got %b want 1", bus1.issue_valid); end
        tick();
        bus0.hilo_done = 1'b0;
        drive(OP_MFHI, 5'd0, 5'd0, 5'd9, 1'b0, 32'h308);
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== 32'h304) begin n_err++; $display("FAIL hilo_mflo_issue: got v=%b pc=%h want v=1 pc=00000304", bus0.issue_valid, bus0.issue_pc); end
        tick();
        bus0.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== 32'h308) begin n_err++; $display("FAIL hilo_mfhi_issue: got v=%b pc=%h want v=1 pc=00000308", bus0.issue_valid, bus0.issue_pc); end
        tick();
        #1;
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL hilo_busy_end: got %b want 0", bus0.busy); end
    endtask

    task automatic test_serialize();
        do_reset();
        bus0.issue_ready = 1'b1;
        drive(OP_LW, 5'd1, 5'd0, 5'd7, 1'b1, 32'h400);
        tick();
        drive(OP_SYSCALL, 5'd0, 5'd0, 5'd0, 1'b0, 32'h404);
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== 32'h400) begin n_err++; $display("FAIL ser_lw_issue: got v=%b pc=%h want v=1 pc=00000400", bus0.issue_valid, bus0.issue_pc); end
        tick();
        bus0.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL ser_held_run: got %b want 0", bus0.issue_valid); end
        tick();
        #1;
        n_cmp++; if (dut0.state_q !== ST_DRAIN) begin n_err++; $display("FAIL ser_state_drain: got %0d want DRAIN", dut0.state_q); end
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL ser_held_drain: got %b want 0", bus0.issue_valid); end
        bus0.wb_valid = 1'b1;
        bus0.wb_rd    = 5'd7;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL ser_held_wb_cycle: got %b want 0", bus0.issue_valid); end
        tick();
        bus0.wb_valid = 1'b0;
        bus0.wb_rd    = 5'd0;
        #1;
        n_cmp++; if (dut0.state_q !== ST_RUN) begin n_err++; $display("FAIL ser_state_run: got %0d want RUN", dut0.state_q); end
        n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== 32'h404) begin n_err++; $display("FAIL ser_syscall_issue: got v=%b pc=%h want v=1 pc=00000404", bus0.issue_valid, bus0.issue_pc); end
        tick();
        // Serializing op with an empty scoreboard goes straight out.
        drive(OP_BREAK, 5'd0, 5'd0, 5'd0, 1'b0, 32'h408);
        tick();
        bus0.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== 32'h408) begin n_err++; $display("FAIL ser_break_direct: got v=%b pc=%h want v=1 pc=00000408", bus0.issue_valid, bus0.issue_pc); end
        tick();
        #1;
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL ser_busy_end: got %b want 0", bus0.busy); end
    endtask

    task automatic test_fifo_full();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(OP_ADDU, 5'd0, 5'd0, 5'd0, 1'b0, 32'h500 + 32'(4 * i));
            #1;
            n_cmp++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_push%0d: got %b want 1", i, bus0.in_ready); end
            tick();
        end
        // Ninth push while full must be refused.
        drive(OP_ADDU, 5'd0, 5'd0, 5'd0, 1'b0, 32'hDEAD);
        #1;
        n_cmp++; if (bus0.in_ready !== 1'b0) begin n_err++; $display("FAIL full_not_ready: got %b want 0", bus0.in_ready); end
        n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== 32'h500) begin n_err++; $display("FAIL full_head: got v=%b pc=%h want v=1 pc=00000500", bus0.issue_valid, bus0.issue_pc); end
        tick();
        bus0.in_valid    = 1'b0;
        bus0.issue_ready = 1'b1;
        tick();
        bus0.issue_ready = 1'b0;
        #1;
        n_cmp++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after_pop: got %b want 1", bus0.in_ready); end
        bus0.issue_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            exp_pc = 32'h500 + 32'(4 * i);
            #1;
            n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== exp_pc) begin n_err++; $display("FAIL full_drain%0d: got v=%b pc=%h want v=1 pc=%h", i, bus0.issue_valid, bus0.issue_pc, exp_pc); end
            tick();
        end
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL full_drained_empty: got %b want 0", bus0.issue_valid); end
        // Streaming push+pop across several pointer wraps.
        for (int k = 0; k < 20; k++) begin
            drive(OP_ADDU, 5'd0, 5'd0, 5'd0, 1'b0, 32'h600 + 32'(4 * k));
            exp_pc = 32'h600 + 32'(4 * (k - 1));
            #1;
            if (k == 0) begin
                n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL wrap_first_empty: got %b want 0", bus0.issue_valid); end
            end else begin
                n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== exp_pc) begin n_err++; $display("FAIL wrap%0d: got v=%b pc=%h want v=1 pc=%h", k, bus0.issue_valid, bus0.issue_pc, exp_pc); end
            end
            tick();
        end
        bus0.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== 32'h64C) begin n_err++; $display("FAIL wrap_last: got v=%b pc=%h want v=1 pc=0000064c", bus0.issue_valid, bus0.issue_pc); end
        tick();
        #1;
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL wrap_busy_end: got %b want 0", bus0.busy); end
    endtask

    task automatic test_flush();
        do_reset();
        bus0.issue_ready = 1'b1;
        drive(OP_LW, 5'd1, 5'd0, 5'd4, 1'b1, 32'h700);
        tick();
        drive(OP_ADDU, 5'd1, 5'd2, 5'd9, 1'b0, 32'h704);
        tick();
        bus0.issue_ready = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            drive(OP_ADDU, 5'd1, 5'd2, 5'd9, 1'b0, 32'h700 + 32'(4 * i));
            tick();
        end
        bus0.in_valid = 1'b0;
        #1;
        n_cmp++; if (dut0.count_q !== 4'd5) begin n_err++; $display("FAIL flush_pre_count: got %0d want 5", dut0.count_q); end
        n_cmp++; if (bus0.issue_valid !== 1'b1 || bus0.issue_pc !== 32'h704) begin n_err++; $display("FAIL flush_pre_head: got v=%b pc=%h want v=1 pc=00000704", bus0.issue_valid, bus0.issue_pc); end
        bus0.flush = 1'b1;
        drive(OP_ADDU, 5'd0, 5'd0, 5'd0, 1'b0, 32'hBAD);
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL flush_gates_valid: got %b want 0", bus0.issue_valid); end
        tick();
        bus0.flush    = 1'b0;
        bus0.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus0.issue_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b want 0", bus0.issue_valid); end
        n_cmp++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", bus0.in_ready); end
        n_cmp++; if (dut0.sb_q !== 32'h0000_0010) begin n_err++; $display("FAIL flush_sb_kept: got %h want 00000010", dut0.sb_q); end
        n_cmp++; if (bus0.busy !== 1'b1) begin n_err++; $display("FAIL flush_busy_sb: got %b want 1", bus0.busy); end
        bus0.wb_valid = 1'b1;
        bus0.wb_rd    = 5'd0;
        tick();
        bus0.wb_valid = 1'b0;
        #1;
        n_cmp++; if (dut0.sb_q !== 32'h0000_0010) begin n_err++; $display("FAIL flush_wb_r0_ignored: got %h want 00000010", dut0.sb_q); end
        bus0.wb_valid = 1'b1;
        bus0.wb_rd    = 5'd4;
        tick();
        bus0.wb_valid = 1'b0;
        bus0.wb_rd    = 5'd0;
        #1;
        n_cmp++; if (dut0.sb_q !== 32'h0) begin n_err++; $display("FAIL flush_wb_r4_clear: got %h want 00000000", dut0.sb_q); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy_end: got %b want 0", bus0.busy); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        bus0.issue_ready = 1'b1;
        drive(OP_LW, 5'd1, 5'd0, 5'd7, 1'b1, 32'h800);
        tick();
        drive(OP_SYSCALL, 5'd0, 5'd0, 5'd0, 1'b0, 32'h804);
        tick();
        bus0.in_valid = 1'b0;
        tick();
        #1;
        n_cmp++; if (dut0.state_q !== ST_DRAIN) begin n_err++; $display("FAIL rst_drain_entered: got %0d want DRAIN", dut0.state_q); end
        // Reset together with flush: reset must also wipe the scoreboard.
        rst_n      = 1'b0;
        bus0.flush = 1'b1;
        tick();
        rst_n      = 1'b1;
        bus0.flush = 1'b0;
        #1;
        n_cmp++; if (dut0.state_q !== ST_RUN) begin n_err++; $display("FAIL rst_state_run: got %0d want RUN", dut0.state_q); end
        n_cmp++; if (dut0.sb_q !== 32'h0) begin n_err++; $display("FAIL rst_sb_clear: got %h want 00000000", dut0.sb_q); end
        n_cmp++; if (bus0.busy !== 1'b0 || bus0.issue_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_outputs: got busy=%b v=%b rdy=%b want 0 0 1", bus0.busy, bus0.issue_valid, bus0.in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw_load();
        test_hilo();
        test_serialize();
        test_fifo_full();
        test_flush();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
